// File: rtl/rx78_kbd_pkg.sv
// Shared types and constants for the RX-78 keyboard port responder.
//   ROWS/COLS      : key matrix geometry (9 rows x 8 columns)
//   KBD_PORT       : default I/O port for strobe write and row read
//   key_loc_t      : {hit, row, col} result of a scan-code lookup
//   scan_to_key()  : PS/2 set-2 scan code -> matrix position table
// Optional build macro RX78_KBD_JOY_EN is consumed by rx78_keyboard.
package rx78_kbd_pkg;

    localparam int ROWS = 9;
    localparam int COLS = 8;
    localparam int KEYS = ROWS * COLS;

    localparam logic [7:0] KBD_PORT = 8'hF4;

    typedef struct packed {
        logic       hit;
        logic [3:0] row;
        logic [2:0] col;
    } key_loc_t;

    function automatic key_loc_t key_at(input logic [3:0] row, input logic [2:0] col);
        key_loc_t k;
        k.hit = 1'b1;
        k.row = row;
        k.col = col;
        return k;
    endfunction

    // Unlisted codes (Esc among them) are misses and never touch the matrix.
    function automatic key_loc_t scan_to_key(input logic ext, input logic [7:0] code);
        key_loc_t k;
        k = '0;
        if (ext) begin
            case (code)
                8'h75:   k = key_at(4'd7, 3'd2);   // up
                8'h72:   k = key_at(4'd7, 3'd3);   // down
                8'h6B:   k = key_at(4'd7, 3'd4);   // left
                8'h74:   k = key_at(4'd7, 3'd5);   // right
                default: k = '0;
            endcase
        end else begin
            case (code)
                8'h45:   k = key_at(4'd0, 3'd0);   // 0
                8'h16:   k = key_at(4'd0, 3'd1);   // 1
                8'h1E:   k = key_at(4'd0, 3'd2);   // 2
                8'h26:   k = key_at(4'd0, 3'd3);   // 3
                8'h25:   k = key_at(4'd0, 3'd4);   // 4
                8'h2E:   k = key_at(4'd0, 3'd5);   // 5
                8'h36:   k = key_at(4'd0, 3'd6);   // 6
                8'h3D:   k = key_at(4'd0, 3'd7);   // 7
                8'h3E:   k = key_at(4'd1, 3'd0);   // 8
                8'h46:   k = key_at(4'd1, 3'd1);   // 9
                8'h1C:   k = key_at(4'd2, 3'd1);   // A
                8'h32:   k = key_at(4'd2, 3'd2);   // B
                8'h21:   k = key_at(4'd2, 3'd3);   // C
                8'h23:   k = key_at(4'd2, 3'd4);   // D
                8'h24:   k = key_at(4'd2, 3'd5);   // E
                8'h2B:   k = key_at(4'd2, 3'd6);   // F
                8'h34:   k = key_at(4'd2, 3'd7);   // G
                8'h33:   k = key_at(4'd3, 3'd0);   // H
                8'h43:   k = key_at(4'd3, 3'd1);   // I
                8'h3B:   k = key_at(4'd3, 3'd2);   // J
                8'h42:   k = key_at(4'd3, 3'd3);   // K
                8'h4B:   k = key_at(4'd3, 3'd4);   // L
                8'h3A:   k = key_at(4'd3, 3'd5);   // M
                8'h31:   k = key_at(4'd3, 3'd6);   // N
                8'h44:   k = key_at(4'd3, 3'd7);   // O
                8'h4D:   k = key_at(4'd4, 3'd0);   // P
                8'h15:   k = key_at(4'd4, 3'd1);   // Q
                8'h2D:   k = key_at(4'd4, 3'd2);   // R
                8'h1B:   k = key_at(4'd4, 3'd3);   // S
                8'h2C:   k = key_at(4'd4, 3'd4);   // T
                8'h3C:   k = key_at(4'd4, 3'd5);   // U
                8'h2A:   k = key_at(4'd4, 3'd6);   // V
                8'h1D:   k = key_at(4'd4, 3'd7);   // W
                8'h22:   k = key_at(4'd5, 3'd0);   // X
                8'h35:   k = key_at(4'd5, 3'd1);   // Y
                8'h1A:   k = key_at(4'd5, 3'd2);   // Z
                8'h5A:   k = key_at(4'd6, 3'd0);   // enter
                8'h66:   k = key_at(4'd6, 3'd1);   // backspace
                8'h29:   k = key_at(4'd8, 3'd0);   // space
                8'h12:   k = key_at(4'd8, 3'd1);   // left shift
                default: k = '0;
            endcase
        end
        return k;
    endfunction

endpackage

// File: rtl/rx78_kbd_map.sv
// Combinational scan-code to key-matrix lookup.
//   ext  : extended (E0-prefixed) code flag
//   code : scan code
//   loc  : {hit, row, col}; hit=0 for unmapped codes
module rx78_kbd_map
    import rx78_kbd_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    output key_loc_t   loc
);

    assign loc = scan_to_key(ext, code);

endmodule

// File: rtl/rx78_keyboard.sv
// RX-78 keyboard port responder: turns ps2_key events into a 9x8 key
// matrix, latches the CPU's row strobe on port writes and returns the
// selected row (1 = pressed) one cycle after a port read.
//   clk, reset      : system clock, async active-high reset
//   ps2_key[10:0]   : {toggle, pressed, extended, code}
//   io_en/wr_n/addr : CPU I/O cycle qualifiers
//   din             : CPU write data (strobe in din[3:0])
//   dout/dout_valid : registered row data and its valid flag
// Build macro RX78_KBD_JOY_EN adds joy1/joy2 inputs on strobes 10/11.
module rx78_keyboard
    import rx78_kbd_pkg::*;
#(
    parameter logic [7:0]  PORT        = KBD_PORT,
    parameter logic [15:0] HOLD_CYCLES = 16'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic        io_en,
    input  logic        wr_n,
    input  logic [7:0]  addr,
    input  logic [7:0]  din,
`ifdef RX78_KBD_JOY_EN
    input  logic [7:0]  joy1,
    input  logic [7:0]  joy2,
`endif
    output logic [7:0]  dout,
    output logic        dout_valid
);

    logic [KEYS-1:0] matrix_q, matrix_d;
    logic [3:0]      strobe_q, strobe_d;
    logic [7:0]      dout_q, dout_d;
    logic            dout_valid_q, dout_valid_d;
    logic [15:0]     timer_q, timer_d;
    key_loc_t        pend_q, pend_d;
    logic            tog_q, tog_d;
    logic            first_q, first_d;

    key_loc_t        loc;
    logic [KEYS-1:0] set_v, clr_v;
    logic [6:0]      loc_idx, pend_idx;
    logic [3:0]      row_sel;
    logic [7:0]      row_data;
    logic            event_fire, port_hit;
    logic            unused_din;

    assign unused_din = ^din[7:4];

    rx78_kbd_map u_map (
        .ext  (ps2_key[8]),
        .code (ps2_key[7:0]),
        .loc  (loc)
    );

    // COLS is 8, so {row,col} is the flat bit index row*8+col.
    assign loc_idx  = {loc.row, loc.col};
    assign pend_idx = {pend_q.row, pend_q.col};
    assign port_hit = io_en && (addr == PORT);
    // The first clock after reset only captures the toggle, never an event.
    assign event_fire = !first_q && (ps2_key[10] != tog_q);
    assign row_sel  = strobe_q - 4'd1;

    always_comb begin
        row_data = 8'h00;
        if (strobe_q != 4'd0 && strobe_q <= 4'(ROWS)) begin
            row_data = matrix_q[{row_sel, 3'b000} +: COLS];
        end
`ifdef RX78_KBD_JOY_EN
        if (strobe_q == 4'd10) row_data = joy1;
        if (strobe_q == 4'd11) row_data = joy2;
`endif
    end

    always_comb begin
        strobe_d     = strobe_q;
        timer_d      = timer_q;
        pend_d       = pend_q;
        tog_d        = ps2_key[10];
        first_d      = 1'b0;
        set_v        = '0;
        clr_v        = '0;
        dout_d       = 8'h00;
        dout_valid_d = 1'b0;

        if (port_hit && !wr_n) strobe_d = din[3:0];

        // Read uses matrix_q, i.e. the state before this cycle's update.
        if (port_hit && wr_n) begin
            dout_d       = row_data;
            dout_valid_d = 1'b1;
        end

        if (timer_q != 16'd0) timer_d = timer_q - 16'd1;

        if (event_fire && loc.hit) begin
            if (ps2_key[9]) begin
                set_v[loc_idx] = 1'b1;
                timer_d        = HOLD_CYCLES;
                if (pend_q.hit && pend_q.row == loc.row && pend_q.col == loc.col) begin
                    pend_d.hit = 1'b0;
                end
            end else if (timer_q <= 16'd1) begin
                // At timer==1 the hold ends this very cycle, so the key
                // goes straight away rather than waiting in the slot.
                clr_v[loc_idx] = 1'b1;
            end else begin
                if (pend_q.hit && (pend_q.row != loc.row || pend_q.col != loc.col)) begin
                    clr_v[pend_idx] = 1'b1;
                end
                pend_d = loc;
            end
        end

        if (timer_q == 16'd1 && timer_d == 16'd0 && pend_q.hit) begin
            clr_v[pend_idx] = 1'b1;
            pend_d.hit      = 1'b0;
        end

        matrix_d = (matrix_q & ~clr_v) | set_v;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            matrix_q     <= '0;
            strobe_q     <= 4'd0;
            dout_q       <= 8'h00;
            dout_valid_q <= 1'b0;
            timer_q      <= 16'd0;
            pend_q       <= '0;
            tog_q        <= 1'b0;
            first_q      <= 1'b1;
        end else begin
            matrix_q     <= matrix_d;
            strobe_q     <= strobe_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            timer_q      <= timer_d;
            pend_q       <= pend_d;
            tog_q        <= tog_d;
            first_q      <= first_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_rx78_keyboard.sv
`timescale 1ns/1ps
module tb_rx78_keyboard;

    localparam int         H = 40;
    localparam logic [7:0] P = 8'hF4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] ps2_key = '0;
    logic        io_en = 1'b0;
    logic        wr_n = 1'b1;
    logic [7:0]  addr = 8'h00;
    logic [7:0]  din = 8'h00;
    logic [7:0]  dout;
    logic        dout_valid;
`ifdef RX78_KBD_JOY_EN
    logic [7:0]  joy1 = 8'h00;
    logic [7:0]  joy2 = 8'h00;
`endif

    rx78_keyboard #(.PORT(P), .HOLD_CYCLES(16'(H))) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_key    (ps2_key),
        .io_en      (io_en),
        .wr_n       (wr_n),
        .addr       (addr),
        .din        (din),
`ifdef RX78_KBD_JOY_EN
        .joy1       (joy1),
        .joy2       (joy2),
`endif
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        bit         ext;
        logic [7:0] code;
        bit         hit;
        int         row;
        int         col;
    } kent_t;

    kent_t      pool[8];
    logic [7:0] m_mat[9];
    logic [3:0] m_strobe;
    int         cyc;
    int         last_press;
    bit         pend_v;
    int         pend_r, pend_c;
    bit         m_first;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];

    function automatic bit lookup(input bit ext, input logic [7:0] code, output int r, output int c);
        r = 0;
        c = 0;
        foreach (pool[i]) begin
            if (pool[i].ext == ext && pool[i].code == code && pool[i].hit) begin
                r = pool[i].row;
                c = pool[i].col;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [7:0] model_row();
        if (m_strobe >= 4'd1 && m_strobe <= 4'd9) return m_mat[m_strobe - 4'd1];
`ifdef RX78_KBD_JOY_EN
        if (m_strobe == 4'd10) return joy1;
        if (m_strobe == 4'd11) return joy2;
`endif
        return 8'h00;
    endfunction

    task automatic model_reset();
        foreach (m_mat[i]) m_mat[i] = 8'h00;
        m_strobe   = 4'd0;
        last_press = -1000000;
        pend_v     = 1'b0;
        m_first    = 1'b1;
    endtask

    // A key stays held until H cycles after the most recent press of any key;
    // a release before then waits in a single pending slot.
    task automatic model_edge(input bit ev, input bit press, input bit ext, input logic [7:0] code);
        logic [7:0] clr[9];
        logic [7:0] set[9];
        int  r, c, age;
        bit  hit, pressed;
        foreach (clr[i]) begin clr[i] = 8'h00; set[i] = 8'h00; end
        if (m_first) begin
            m_first = 1'b0;
            return;
        end
        age     = cyc - last_press;
        hit     = ev && lookup(ext, code, r, c);
        pressed = 1'b0;
        if (hit && press) begin
            set[r][c] = 1'b1;
            if (pend_v && pend_r == r && pend_c == c) pend_v = 1'b0;
            last_press = cyc;
            pressed    = 1'b1;
        end else if (hit) begin
            if (age >= H) clr[r][c] = 1'b1;
            else begin
                if (pend_v && (pend_r != r || pend_c != c)) clr[pend_r][pend_c] = 1'b1;
                pend_v = 1'b1;
                pend_r = r;
                pend_c = c;
            end
        end
        if (!pressed && pend_v && age == H) begin
            clr[pend_r][pend_c] = 1'b1;
            pend_v = 1'b0;
        end
        foreach (m_mat[i]) m_mat[i] = (m_mat[i] & ~clr[i]) | set[i];
    endtask

    // ---------------- stimulus ----------------
    // op: 0 idle, 1 write, 2 read
    task automatic step(input bit ev, input bit press, input bit ext, input logic [7:0] code,
                        input int op, input logic [7:0] a, input logic [7:0] d);
        io_en = (op != 0);
        wr_n  = (op != 1);
        addr  = a;
        din   = d;
        if (ev) ps2_key = {~ps2_key[10], press, ext, code};
        if (op == 2 && a == P) exp_q.push_back(model_row());
        model_edge(ev, press, ext, code);
        if (op == 1 && a == P) m_strobe = d[3:0];
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 0, 8'h00, 8'h00);
    endtask

    task automatic wr(input logic [3:0] s);
        logic [3:0] hi;
        hi = 4'($urandom_range(0, 15));
        step(0, 0, 0, 8'h00, 1, P, {hi, s});
    endtask

    task automatic rd();
        step(0, 0, 0, 8'h00, 2, P, 8'h00);
    endtask

    task automatic key(input bit press, input bit ext, input logic [7:0] code);
        step(1, press, ext, code, 0, 8'h00, 8'h00);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #2;
        io_en = 1'b0;
        reset = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (dout !== 8'h00 || dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: dout=%02h valid=%0b, required 00/0", dout, dout_valid);
        end
        repeat (n) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        reset = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [7:0] e;
        if (dout_valid === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: dout=%02h, required no valid output", dout);
            end else begin
                e = exp_q.pop_front();
                if (dout !== e) begin
                    n_fail++;
                    $display("FAIL row_read: dout=%02h, required %02h (cycle %0d)", dout, e, cyc);
                end
            end
        end
    end

    initial begin
        pool[0] = '{0, 8'h1C, 1, 2, 1};   // A
        pool[1] = '{0, 8'h5A, 1, 6, 0};   // Enter
        pool[2] = '{0, 8'h29, 1, 8, 0};   // Space
        pool[3] = '{1, 8'h75, 1, 7, 2};   // Up (extended)
        pool[4] = '{0, 8'h32, 1, 2, 2};   // B
        pool[5] = '{0, 8'h33, 1, 3, 0};   // H
        pool[6] = '{0, 8'h76, 0, 0, 0};   // Esc: unmapped
        pool[7] = '{1, 8'h1C, 0, 0, 0};   // extended 1C: unmapped
        cyc = 0;
        model_reset();

        do_reset(3);
        idle(1);
        wr(4'd3);
        rd();
        step(0, 0, 0, 8'h00, 2, 8'hF5, 8'h00);
        idle(2);

        key(1, 0, 8'h1C);
        rd();
        idle(H + 10);
        key(0, 0, 8'h1C);
        rd();
        rd();

        key(1, 0, 8'h1C);
        idle(4);
        key(0, 0, 8'h1C);
        for (int i = 0; i < H + 4; i++) rd();

        key(1, 0, 8'h5A);
        key(1, 1, 8'h75);
        key(1, 0, 8'h76);
        for (int s = 1; s <= 9; s++) begin
            wr(4'(s));
            rd();
        end

        wr(4'd0);
        rd();
        wr(4'd12);
        rd();
        key(1, 0, 8'h29);
        key(0, 0, 8'h5A);
        wr(4'd7);
        rd();
        do_reset(2);
        idle(1);
        wr(4'd7);
        rd();
        wr(4'd9);
        rd();
        idle(H + 5);
        rd();
        wr(4'd7);
        rd();

`ifdef RX78_KBD_JOY_EN
        joy1 = 8'h11;
        joy2 = 8'h22;
`endif
        wr(4'd10);
        rd();
        wr(4'd11);
        rd();

        for (int i = 0; i < 3000; i++) begin
            bit         ev, pr;
            int         k, op;
            logic [7:0] a, d;
            ev = ($urandom_range(0, 5) == 0);
            pr = $urandom_range(0, 1) == 1;
            k  = $urandom_range(0, 7);
            op = $urandom_range(0, 15);
            a  = P;
            d  = 8'($urandom_range(0, 255));
            if (op <= 1) op = 1;
            else if (op <= 5) op = 2;
            else if (op == 6) begin
                op = 2;
                a  = 8'($urandom_range(0, 255));
                if (a == P) a = 8'h00;
            end else if (op == 7) begin
                op = 1;
                a  = 8'($urandom_range(0, 255));
                if (a == P) a = 8'h01;
            end else op = 0;
`ifdef RX78_KBD_JOY_EN
            if ($urandom_range(0, 63) == 0) begin
                joy1 = 8'($urandom_range(0, 255));
                joy2 = 8'($urandom_range(0, 255));
            end
`endif
            step(ev, pr, pool[k].ext, pool[k].code, op, a, d);
        end

        idle(3);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_valid: %0d reads never answered, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rx78_keyboard.md
Name: rx78_keyboard

Overview:
- CPU-side responder for the RX-78 keyboard I/O port 0xF4.
- Converts MiSTer ps2_key events into a 9-row x 8-column key matrix.
- The Z80 writes a row strobe to 0xF4 and reads the selected row back from 0xF4.
- Sits beside the top-level I/O decoder. Its registered data output replaces the constant 0x00 now returned for port 0xF4.

Parameters:
- PORT, 8'hF4, I/O address decoded for strobe write and row read.
- HOLD_CYCLES, 16'd50000, minimum clk cycles a key stays pressed in the matrix after its press event.

Ports:
- clk  in  1  system clock, same domain as the CPU.
- reset  in  1  asynchronous, active-high.
- ps2_key  in  11  [10] toggle per event, [9] pressed, [8] extended, [7:0] scan code.
- io_en  in  1  high while the CPU I/O cycle is active (~iorq_n).
- wr_n  in  1  CPU write strobe, active-low.
- addr  in  8  CPU address [7:0].
- din  in  8  CPU data out.
- dout  out  8  row data, active-high (1 = pressed).
- dout_valid  out  1  high when dout carries a PORT read result; the top level muxes on it.

Behaviour:
- Reset (async): matrix = 0, strobe = 0, dout = 0x00, dout_valid = 0, timer = 0, pending release cleared, toggle tracker <= ps2_key[10] on the first clk after release.
- Strobe register (4 bits):
  - io_en & ~wr_n & addr==PORT: strobe <= din[3:0] every such cycle (idempotent over multi-cycle writes).
  - din[7:4] ignored.
- Read, latency 1:
  - Each clk: if io_en & wr_n & addr==PORT, then dout <= row_data and dout_valid <= 1.
  - Otherwise dout <= 0x00 and dout_valid <= 0.
  - row_data = matrix[strobe-1] for strobe 1..9. Strobe 0 or 10..15 gives 0x00.
- Event detect:
  - An event fires when ps2_key[10] differs from the stored toggle; the tracker updates the same cycle.
  - The map lookup gives {hit, row[3:0], col[2:0]}. A miss is dropped.
- Press (hit, [9]=1):
  - Sets matrix[row][col], loads timer = HOLD_CYCLES.
  - If a pending release targets the same key, that pending release is cancelled.
- Release (hit, [9]=0):
  - If timer==0, clear the bit immediately.
  - Else store in the pending slot {valid,row,col}.
  - If the slot is already valid with a different key, first clear that older key's bit the same cycle, then overwrite the slot.
- Timer:
  - Decrements when nonzero.
  - On the cycle it transitions 1->0 with the slot valid, clear the pending key and invalidate the slot.
- Simultaneous event and read: the read samples the matrix before that cycle's update.
- Matrix writes use a next-state variable so a clear and a set in one cycle both apply; set wins on the same bit.
- Holding multiple keys is legal; all bits stay independent.

Optional Feature:
- RX78_KBD_JOY_EN
- Defined:
  - Adds ports joy1, joy2 (in, 8, active-high: up,down,left,right,b1,b2,b3,b4 on bits 0..7).
  - Strobe 10 returns joy1; strobe 11 returns joy2.
- Undefined:
  - No joy ports.
  - Strobe 10/11 returns 0x00.

Decomposition:
- Package rx78_kbd_pkg holds:
  - ROWS = 9, COLS = 8.
  - The default PORT constant.
  - key_loc_t {hit,row,col}.
  - The normative scan-code table as a constant function.
- Sub-module rx78_kbd_map: purely combinational {ext,code} -> key_loc_t.
- Normative table entries for test:
  - 0x1C 'A' -> row 2 col 1.
  - 0x5A Enter -> row 6 col 0.
  - 0x29 Space -> row 8 col 0.
  - Extended 0x75 Up -> row 7 col 2.
  - 0x76 Esc -> miss.

Test Plan:
- Reset, then strobe=3, read 0xF4 -> dout=0x00, dout_valid=1 one cycle after the read cycle. A non-F4 read gives dout_valid=0.
- Press 'A' (toggle, [9]=1, 0x1C), strobe=3, read -> 0x02. Release after HOLD_CYCLES+10 -> the next read gives 0x00.
- Press 'A', release 5 cycles later -> the bit stays set for HOLD_CYCLES cycles after the press, then clears. Reads at HOLD_CYCLES-2 give 0x02; reads at HOLD_CYCLES+2 give 0x00.
- Press Enter and extended Up together -> strobe 7 reads 0x01, strobe 8 reads 0x04. Esc is ignored: no matrix change.
- Strobe written as 0x00 and 0x0C with keys held -> reads give 0x00. Assert reset mid-hold, with the slot pending -> matrix cleared and the pending release discarded.
- With RX78_KBD_JOY_EN: joy1=0x11, strobe=10 -> read gives 0x11. Without the macro the same stimulus gives 0x00.
